// File: rtl/tc2sm_pkg.sv
// Shared types and helpers for the bit-serial two's-complement to sign-magnitude decoder.
package tc2sm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } tc2sm_state_t;

    // Width of a counter that must hold the values 0..width.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/tc2sm_bit_cell.sv
// One LSB-first step of the copy-until-first-one-then-invert negation rule.
module tc2sm_bit_cell (
    input  logic b,
    input  logic neg,
    input  logic seen_one,
    output logic r,
    output logic seen_one_next
);

    assign r             = (neg & seen_one) ? ~b : b;
    assign seen_one_next = seen_one | b;

endmodule

// File: rtl/tc2sm_serial.sv
// Bit-serial two's-complement to sign-magnitude decoder with valid/ready on both sides.
// Optional build macro: TC2SM_FASTPOS_EN (non-negative words skip the serial pass).
module tc2sm_serial
    import tc2sm_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [WIDTH-2:0] out_mag,
    output logic             out_ovf,
    output logic             busy
);

    localparam int unsigned    CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    tc2sm_state_t     state, state_nxt;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] result_nxt;
    logic [CW-1:0]    cnt;
    logic             neg;
    logic             seen_one;
    logic             r;
    logic             seen_one_nxt;
    logic             accept;
    logic             last_step;

    tc2sm_bit_cell u_cell (
        .b             (sr[0]),
        .neg           (neg),
        .seen_one      (seen_one),
        .r             (r),
        .seen_one_next (seen_one_nxt)
    );

    assign in_ready   = (state == IDLE) & ~rst;
    assign out_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign accept     = in_valid & in_ready;
    assign last_step  = (state == SHIFT) && (cnt == LAST);
    assign result_nxt = {r, sr[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef TC2SM_FASTPOS_EN
                    state_nxt = in_data[WIDTH-1] ? SHIFT : DONE;
`else
                    state_nxt = SHIFT;
`endif
                end
            end
            SHIFT:   if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result bits enter at the MSB, so after WIDTH steps sr holds the full result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr       <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            seen_one <= 1'b0;
            out_sign <= 1'b0;
            out_mag  <= '0;
            out_ovf  <= 1'b0;
        end else begin
            if (accept) begin
                sr       <= in_data;
                neg      <= in_data[WIDTH-1];
                seen_one <= 1'b0;
                cnt      <= '0;
`ifdef TC2SM_FASTPOS_EN
                if (!in_data[WIDTH-1]) begin
                    out_sign <= 1'b0;
                    out_mag  <= in_data[WIDTH-2:0];
                    out_ovf  <= 1'b0;
                end
`endif
            end
            if (state == SHIFT) begin
                sr       <= result_nxt;
                seen_one <= seen_one_nxt;
                cnt      <= cnt + CW'(1);
                if (last_step) begin
                    out_sign <= neg;
                    out_mag  <= result_nxt[WIDTH-2:0];
                    out_ovf  <= neg & r;
                end
            end
        end
    end

endmodule

// File: tb/tb_tc2sm_serial.sv
// Directed WIDTH=4 checks plus a shuffled WIDTH=8 sweep of all input words.
module tb_tc2sm_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned total  = 0;
    int unsigned passed = 0;

    logic       rst4, iv4, ir4, ov4, or4, os4, of4, busy4;
    logic [3:0] id4;
    logic [2:0] om4;
    logic       rst8, iv8, ir8, ov8, or8, os8, of8, busy8;
    logic [7:0] id8;
    logic [6:0] om8;

    tc2sm_serial #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
        .out_valid(ov4), .out_ready(or4), .out_sign(os4), .out_mag(om4),
        .out_ovf(of4), .busy(busy4)
    );

    tc2sm_serial #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .in_data(id8),
        .out_valid(ov8), .out_ready(or8), .out_sign(os8), .out_mag(om8),
        .out_ovf(of8), .busy(busy8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: decode value arithmetically, then take sign / |value| / overflow.
    task automatic ref_model(input int unsigned w, input int unsigned d,
                             output int unsigned s, output int unsigned m,
                             output int unsigned o, output int unsigned lat);
        int v;
        int unsigned half;
        half = 1 << (w - 1);
        v    = (d >= half) ? int'(d) - int'(2 * half) : int'(d);
        s    = (v < 0) ? 1 : 0;
        m    = (v < 0) ? int'(-v) : int'(v);
        o    = (m == half) ? 1 : 0;
        m    = m % half;
        lat  = w;
`ifdef TC2SM_FASTPOS_EN
        if (v >= 0) lat = 0;
`endif
    endtask

    task automatic txn4(input logic [3:0] d, input int unsigned hold, input string tag);
        int unsigned s, m, o, elat, n;
        ref_model(4, d, s, m, o, elat);
        check({tag, ":in_ready"}, ir4, 1);
        iv4 = 1'b1; id4 = d;
        @(posedge clk); @(negedge clk);
        iv4 = 1'b0; id4 = 4'($urandom);
        n = 0;
        while (!ov4 && n < 20) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
        check({tag, ":edges_after_accept"}, n, elat);
        check({tag, ":sign"}, os4, s);
        check({tag, ":mag"}, om4, m);
        check({tag, ":ovf"}, of4, o);
        repeat (hold) begin
            @(posedge clk); @(negedge clk);
            check({tag, ":held_valid"}, ov4, 1);
            check({tag, ":held_mag"}, om4, m);
            check({tag, ":held_sign"}, os4, s);
            check({tag, ":held_in_ready"}, ir4, 0);
        end
        or4 = 1'b1;
        @(posedge clk); @(negedge clk);
        or4 = 1'b0;
        check({tag, ":valid_dropped"}, ov4, 0);
        check({tag, ":ready_back"}, ir4, 1);
    endtask

    task automatic txn8(input logic [7:0] d, input int unsigned hold);
        int unsigned s, m, o, elat, n;
        string tag;
        tag = $sformatf("w8_%02h", d);
        ref_model(8, d, s, m, o, elat);
        iv8 = 1'b1; id8 = d;
        @(posedge clk); @(negedge clk);
        iv8 = 1'b0; id8 = 8'($urandom);
        n = 0;
        while (!ov8 && n < 30) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
        check({tag, ":edges_after_accept"}, n, elat);
        check({tag, ":sign"}, os8, s);
        check({tag, ":mag"}, om8, m);
        check({tag, ":ovf"}, of8, o);
        repeat (hold) begin
            @(posedge clk); @(negedge clk);
            check({tag, ":held"}, {ov8, os8, om8, of8}, {1'b1, 1'(s), 7'(m), 1'(o)});
        end
        or8 = 1'b1;
        @(posedge clk); @(negedge clk);
        or8 = 1'b0;
        check({tag, ":ready_back"}, ir8, 1);
    endtask

    initial begin
        logic [7:0] perm [256];
        logic [7:0] tmp;
        int unsigned j;
        bit any_valid;

        rst4 = 1'b1; rst8 = 1'b1;
        iv4 = 1'b0; or4 = 1'b0; id4 = '0;
        iv8 = 1'b0; or8 = 1'b0; id8 = '0;
        #1;
        check("rst:in_ready", ir4, 0);
        check("rst:outs", {ov4, os4, om4, of4, busy4}, 0);
        @(negedge clk); @(negedge clk);
        rst4 = 1'b0; rst8 = 1'b0;
        #1;
        check("post_rst:in_ready", ir4, 1);
        check("post_rst:busy", busy4, 0);
        @(negedge clk);

        txn4(4'b0101, 0, "pos5");
        txn4(4'b1011, 0, "neg5");
        txn4(4'b1111, 0, "neg1");
        txn4(4'b0000, 0, "zero");
        txn4(4'b0110, 3, "backpressure");
        txn4(4'b1000, 0, "min_ovf");

        // Reset while the serial counter sits at 2.
        iv4 = 1'b1; id4 = 4'b1011;
        @(posedge clk); @(negedge clk);
        iv4 = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst4 = 1'b1;
        #1;
        check("midrst:outs", {ov4, os4, om4, of4}, 0);
        check("midrst:busy", busy4, 0);
        check("midrst:in_ready", ir4, 0);
        @(negedge clk);
        rst4 = 1'b0;
        any_valid = 1'b0;
        repeat (8) begin
            @(posedge clk); @(negedge clk);
            if (ov4) any_valid = 1'b1;
        end
        check("midrst:no_stale_valid", any_valid, 0);
        txn4(4'b1110, 0, "after_rst");

        for (int i = 0; i < 256; i++) perm[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            j = $urandom_range(i, 0);
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        for (int i = 0; i < 256; i++) txn8(perm[i], $urandom_range(2, 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
